// File: rtl/gc_scan_if.sv
// Host-side handshake bundle of the scan sequencer: command, load-word and unload-word channels.
interface gc_scan_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ready;
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic              rd_ready;

  modport master (
    output cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/gc_scan_ctrl.sv
// Scan-chain sequencer: streams load words into a scan-enable flop chain while unloading
// its previous contents word-by-word, and can issue a single functional-capture cycle.
module gc_scan_ctrl #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic     C,
  input  logic     R,
  gc_scan_if.slave bus,
  output logic     scan_se,
  output logic     scan_e,
  output logic     scan_si,
  input  logic     scan_so,
  output logic     busy,
  output logic     done
);
  localparam int unsigned N_WORDS = CHAIN_LEN / WORD_W;
  localparam int unsigned CNT_W   = $clog2(N_WORDS) + 1;
  localparam int unsigned BIT_W   = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, CAPT, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  word_cnt, word_cnt_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [WORD_W-1:0] in_sr, in_sr_nx;
  logic [WORD_W-1:0] out_sr, out_sr_nx;

  // Unload word comes straight from the capture register; it only moves during SHIFT.
  assign bus.rd_data = out_sr;

  // Next-state and datapath update.
  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    bit_cnt_nx  = bit_cnt;
    in_sr_nx    = in_sr;
    out_sr_nx   = out_sr;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'b00: begin
              state_nx    = FETCH;
              word_cnt_nx = '0;
            end
            2'b01:   state_nx = CAPT;
            default: state_nx = DONE;
          endcase
        end
      end
      FETCH: begin
        if (bus.wr_valid) begin
          in_sr_nx   = bus.wr_data;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        // scan_so is the tail value before this edge moves the chain.
        in_sr_nx   = in_sr >> 1;
        out_sr_nx  = {scan_so, out_sr[WORD_W-1:1]};
        bit_cnt_nx = bit_cnt + BIT_W'(1);
        if (bit_cnt == BIT_W'(WORD_W - 1)) begin
          state_nx    = DRAIN;
          word_cnt_nx = word_cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (bus.rd_ready) begin
          state_nx = (word_cnt == CNT_W'(N_WORDS)) ? DONE : FETCH;
        end
      end
      CAPT:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state so they
  // line up with the state they describe and never glitch.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state         <= IDLE;
      word_cnt      <= '0;
      bit_cnt       <= '0;
      in_sr         <= '0;
      out_sr        <= '0;
      scan_se       <= 1'b0;
      scan_e        <= 1'b0;
      scan_si       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
    end else begin
      state         <= state_nx;
      word_cnt      <= word_cnt_nx;
      bit_cnt       <= bit_cnt_nx;
      in_sr         <= in_sr_nx;
      out_sr        <= out_sr_nx;
      scan_se       <= (state_nx == SHIFT);
      scan_e        <= (state_nx == CAPT);
      scan_si       <= (state_nx == SHIFT) && in_sr_nx[0];
      busy          <= (state_nx != IDLE);
      done          <= (state_nx == DONE);
      bus.cmd_ready <= (state_nx == IDLE);
      bus.wr_ready  <= (state_nx == FETCH);
      bus.rd_valid  <= (state_nx == DRAIN);
    end
  end
endmodule

// File: tb/tb_gc_scan_ctrl.sv
// Randomized bench for gc_scan_ctrl driving a behavioural 16-flop scan chain; expected unload
// words and chain contents come from the positional bit-order rules, not from the controller.
module tb_gc_scan_ctrl;
  localparam int unsigned CL = 16;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = CL / W;

  logic C = 1'b0;
  logic R;
  logic scan_se, scan_e, scan_si, scan_so, busy, done;
  logic chain_clr;
  logic [CL-1:0] chain;
  logic [CL-1:0] d_in;

  gc_scan_if #(.WORD_W(W)) bus ();

  gc_scan_ctrl #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .C(C), .R(R), .bus(bus),
    .scan_se(scan_se), .scan_e(scan_e), .scan_si(scan_si), .scan_so(scan_so),
    .busy(busy), .done(done)
  );

  always #5 C = ~C;

  // Scan chain: position 0 is the head (SI side), position CL-1 the tail (SO).
  always @(posedge C or posedge chain_clr) begin
    if (chain_clr)    chain <= '0;
    else if (scan_se) chain <= {chain[CL-2:0], scan_si};
    else if (scan_e)  chain <= d_in;
  end
  assign scan_so = chain[CL-1];

  // Protocol monitor sampled mid-cycle.
  int   se_cnt = 0, e_cnt = 0, done_cnt = 0;
  int   se_e_ovl = 0, rdy_done_ovl = 0, rd_unstable = 0;
  logic rd_hold = 1'b0;
  logic [W-1:0] rd_prev = '0;
  always @(negedge C) begin
    se_cnt   <= se_cnt + int'(scan_se);
    e_cnt    <= e_cnt + int'(scan_e);
    done_cnt <= done_cnt + int'(done);
    if (scan_se && scan_e)       se_e_ovl     <= se_e_ovl + 1;
    if (bus.cmd_ready && done)   rdy_done_ovl <= rdy_done_ovl + 1;
    if (rd_hold && bus.rd_valid && bus.rd_data !== rd_prev) rd_unstable <= rd_unstable + 1;
    rd_hold <= bus.rd_valid && !bus.rd_ready;
    rd_prev <= bus.rd_data;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  logic [W-1:0]  ld_w [NW];
  logic [W-1:0]  rd_w [NW];
  logic [CL-1:0] snap;

  // Unload word k bit j is the pre-command content of chain position CL-1-(k*W+j).
  function automatic logic [W-1:0] exp_rd(input logic [CL-1:0] s, input int k);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) r[j] = s[CL-1-(k*W+j)];
    return r;
  endfunction

  // Load bit n (word n/W, bit n%W) is the n-th bit in, so it lands at position CL-1-n.
  function automatic logic [CL-1:0] exp_chain();
    logic [CL-1:0] c;
    c = '0;
    for (int n = 0; n < CL; n++) c[CL-1-n] = ld_w[n/W][n%W];
    return c;
  endfunction

  task automatic issue_cmd(input logic [1:0] op);
    int t;
    t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    while (!bus.cmd_ready && t < 50) begin tick(); t++; end
    chk("cmd_ready_seen", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic data_phase(input int wr_stall, input int rd_stall);
    for (int k = 0; k < NW; k++) begin
      int t;
      t = 0;
      while (!bus.wr_ready && t < 50) begin tick(); t++; end
      chk("wr_ready_seen", 32'(bus.wr_ready), 32'd1);
      if (wr_stall > 0) begin
        repeat (wr_stall) tick();
        chk("se_in_wr_stall", 32'(scan_se), 32'd0);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = ld_w[k];
      tick();
      bus.wr_valid = 1'b0;
      bus.wr_data  = W'($urandom);
      t = 0;
      while (!bus.rd_valid && t < 50) begin tick(); t++; end
      chk("rd_valid_seen", 32'(bus.rd_valid), 32'd1);
      if (rd_stall > 0) begin
        repeat (rd_stall) tick();
        chk("se_in_rd_stall", 32'(scan_se), 32'd0);
      end
      rd_w[k] = bus.rd_data;
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin tick(); t++; end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_shift_result(input logic [CL-1:0] s);
    for (int k = 0; k < NW; k++) chk("rd_word", 32'(rd_w[k]), 32'(exp_rd(s, k)));
    chk("chain_after", 32'(chain), 32'(exp_chain()));
  endtask

  // Full SHIFT command; junk_cmd keeps a CAPTURE request pending while busy.
  task automatic run_shift(input int wr_stall, input int rd_stall, input bit junk_cmd);
    int se0, e0, d0;
    snap = chain;
    se0  = se_cnt;
    e0   = e_cnt;
    d0   = done_cnt;
    issue_cmd(2'b00);
    if (junk_cmd) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
    end
    data_phase(wr_stall, rd_stall);
    wait_done();
    bus.cmd_valid = 1'b0;
    tick();
    check_shift_result(snap);
    chk("se_cycles", 32'(se_cnt - se0), 32'(CL));
    chk("e_cycles_shift", 32'(e_cnt - e0), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [CL-1:0] exp_c;
    int se0, e0, d0;
    R             = 1'b1;
    chain_clr     = 1'b1;
    d_in          = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (3) @(posedge C);
    #1;
    chk("rst_scan_se", 32'(scan_se), 32'd0);
    chk("rst_scan_e", 32'(scan_e), 32'd0);
    chk("rst_scan_si", 32'(scan_si), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    R         = 1'b0;
    chain_clr = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Cleared chain, then reload with zeros to get the first words back.
    ld_w[0] = 8'hA5; ld_w[1] = 8'h3C;
    run_shift(0, 0, 1'b0);
    ld_w[0] = 8'h00; ld_w[1] = 8'h00;
    run_shift(0, 0, 1'b0);
    chk("reload_word0", 32'(rd_w[0]), 32'hA5);
    chk("reload_word1", 32'(rd_w[1]), 32'h3C);

    // Stalled producer and consumer.
    for (int k = 0; k < NW; k++) ld_w[k] = W'($urandom);
    run_shift(5, 3, 1'b0);

    // Random words, random stalls, stray CAPTURE requests while busy.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NW; k++) ld_w[k] = W'($urandom);
      run_shift(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'(i % 2));
    end

    // Functional capture.
    d_in = 16'hBEEF;
    se0 = se_cnt; e0 = e_cnt; d0 = done_cnt;
    issue_cmd(2'b01);
    chk("capt_scan_e", 32'(scan_e), 32'd1);
    chk("capt_scan_se", 32'(scan_se), 32'd0);
    tick();
    chk("capt_done", 32'(done), 32'd1);
    chk("capt_e_off", 32'(scan_e), 32'd0);
    tick();
    chk("capt_chain", 32'(chain), 32'hBEEF);
    chk("capt_e_cycles", 32'(e_cnt - e0), 32'd1);
    chk("capt_se_cycles", 32'(se_cnt - se0), 32'd0);
    chk("capt_done_pulses", 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < NW; k++) ld_w[k] = W'($urandom);
    run_shift(0, 0, 1'b0);

    // Reset while the first word is mid-shift (three bits in).
    snap = chain;
    d0   = done_cnt;
    ld_w[0] = W'($urandom);
    issue_cmd(2'b00);
    bus.wr_valid = 1'b1;
    bus.wr_data  = ld_w[0];
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    R = 1'b1;
    #1;
    chk("abort_scan_se", 32'(scan_se), 32'd0);
    chk("abort_scan_e", 32'(scan_e), 32'd0);
    chk("abort_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_c = {snap[CL-4:0], ld_w[0][0], ld_w[0][1], ld_w[0][2]};
    chk("abort_chain", 32'(chain), 32'(exp_c));
    repeat (2) tick();
    chk("abort_chain_held", 32'(chain), 32'(exp_c));
    R = 1'b0;
    tick();
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // NOP command.
    se0 = se_cnt; e0 = e_cnt; d0 = done_cnt;
    issue_cmd(2'b11);
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_busy", 32'(busy), 32'd1);
    tick();
    chk("nop_done_off", 32'(done), 32'd0);
    chk("nop_idle", 32'(bus.cmd_ready), 32'd1);
    chk("nop_se_e", 32'((se_cnt - se0) + (e_cnt - e0)), 32'd0);
    chk("nop_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Back-to-back SHIFT commands with cmd_valid held high throughout.
    for (int k = 0; k < NW; k++) ld_w[k] = W'($urandom);
    snap = chain;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    tick();
    data_phase(0, 0);
    wait_done();
    chk("b2b_ready_at_done", 32'(bus.cmd_ready), 32'd0);
    check_shift_result(snap);
    snap = chain;
    for (int k = 0; k < NW; k++) ld_w[k] = W'($urandom);
    tick();
    chk("b2b_idle_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("b2b_accepted", 32'(bus.wr_ready), 32'd1);
    bus.cmd_valid = 1'b0;
    data_phase(0, 0);
    wait_done();
    tick();
    check_shift_result(snap);

    chk("se_e_overlap", 32'(se_e_ovl), 32'd0);
    chk("ready_done_overlap", 32'(rdy_done_ovl), 32'd0);
    chk("rd_data_stable", 32'(rd_unstable), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
